write_arbiter_rr: RTL and testbench

- Parametrised M-master × S-slave write-path arbiter for the AXI-lite interconnect.
- Per-slave round-robin arbitration on the write address (AW) channel.
- Tracks accepted writes in ordering FIFOs of depth DEPTH:
  - routes each master's W data to the slave it addressed, in AW-acceptance order;
  - returns each slave's B response to the originating master in the same order.
- Sits between the master-side and slave-side mux/demux fabric; drives only grant and select lines, never data.

---
 rtl/write_arbiter_rr_pkg.sv | 28 ++
 rtl/write_arbiter_rr_arb_fifo.sv | 57 +++++
 rtl/write_arbiter_rr.sv | 140 ++++++++++++++
 tb/tb_write_arbiter_rr.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/write_arbiter_rr_pkg.sv
// rtl/write_arbiter_rr_pkg.sv - shared widths and address decode for the write-path arbiter
package write_arbiter_rr_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int calc_mw(input int m);
        return idx_width(m);
    endfunction

    function automatic int calc_sw(input int s);
        return idx_width(s);
    endfunction

    // slice_size and s are powers of two, so the decode is a shift plus mask
    function automatic logic [31:0] decode_slave(input logic [63:0] addr,
                                                 input logic [63:0] slice_size,
                                                 input int unsigned s);
        int sh;
        sh = 0;
        for (int i = 0; i < 64; i++) begin
            if (slice_size == (64'd1 << i)) sh = i;
        end
        return 32'((addr >> sh) & (64'(s) - 64'd1));
    endfunction

endpackage

// File: rtl/write_arbiter_rr_arb_fifo.sv
// rtl/write_arbiter_rr_arb_fifo.sv - small ordering FIFO with registered count
module arb_fifo
    import write_arbiter_rr_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full
);
    localparam int AW = idx_width(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push_ok, pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    // full/empty come from the registered count, so a same-cycle pop never frees a slot
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        mem_d    = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = din;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/write_arbiter_rr.sv
// rtl/write_arbiter_rr.sv - M x S AXI-lite write arbiter: round-robin AW, ordered W and B routing
module write_arbiter_rr
    import write_arbiter_rr_pkg::*;
#(
    parameter int          M          = 4,
    parameter int          S          = 4,
    parameter int          DEPTH      = 4,
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] SLICE_SIZE = 32'h80
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [M-1:0]              aw_valid_f,
    input  logic [M*ADDR_WIDTH-1:0]   aw_addr_f,
    output logic [M-1:0]              aw_grant_f,
    output logic [M*calc_sw(S)-1:0]   aw_sel_f,
    input  logic [M-1:0]              w_valid_f,
    input  logic [M-1:0]              w_last_f,
    output logic [M-1:0]              w_grant_f,
    output logic [M*calc_sw(S)-1:0]   w_sel_f,
    input  logic [S-1:0]              b_valid_f,
    input  logic [M-1:0]              b_ready_f,
    output logic [S-1:0]              b_grant_f,
    output logic [S*calc_mw(M)-1:0]   b_sel_f
);
    localparam int MW = calc_mw(M);
    localparam int SW = calc_sw(S);

    logic [SW-1:0] aw_sel [M];
    logic [SW-1:0] mq_head [M];
    logic [M-1:0]  mq_empty, mq_full, mq_pop;
    logic [MW-1:0] wq_head [S], wq_din [S], bq_head [S], bq_din [S];
    logic [S-1:0]  wq_empty, wq_full, wq_push, wq_pop;
    logic [S-1:0]  bq_empty, bq_full, bq_push, bq_pop;
    logic [MW-1:0] rr_ptr_q [S];
    logic [MW-1:0] rr_ptr_d [S];

    // {found, index} of the first requester at or after ptr, wrapping modulo M
    function automatic logic [MW:0] rr_pick(input logic [M-1:0] req, input logic [MW-1:0] ptr);
        logic [MW:0] res;
        int          idx;
        res = '0;
        for (int i = M - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % M;
            if (req[idx]) res = {1'b1, MW'(idx)};
        end
        return res;
    endfunction

    genvar gm, gs;
    generate
        for (gm = 0; gm < M; gm++) begin : g_mq
            assign aw_sel[gm] = SW'(decode_slave(64'(aw_addr_f[gm*ADDR_WIDTH +: ADDR_WIDTH]),
                                                 64'(SLICE_SIZE), S));
            assign aw_sel_f[gm*SW +: SW] = aw_sel[gm];
            arb_fifo #(.DATA_WIDTH(SW), .DEPTH(DEPTH)) u_mq (
                .clk(clk), .clr(clr), .push(aw_grant_f[gm]), .pop(mq_pop[gm]),
                .din(aw_sel[gm]), .head(mq_head[gm]), .empty(mq_empty[gm]), .full(mq_full[gm])
            );
        end
        for (gs = 0; gs < S; gs++) begin : g_sq
            arb_fifo #(.DATA_WIDTH(MW), .DEPTH(DEPTH)) u_wq (
                .clk(clk), .clr(clr), .push(wq_push[gs]), .pop(wq_pop[gs]),
                .din(wq_din[gs]), .head(wq_head[gs]), .empty(wq_empty[gs]), .full(wq_full[gs])
            );
            arb_fifo #(.DATA_WIDTH(MW), .DEPTH(DEPTH)) u_bq (
                .clk(clk), .clr(clr), .push(bq_push[gs]), .pop(bq_pop[gs]),
                .din(bq_din[gs]), .head(bq_head[gs]), .empty(bq_empty[gs]), .full(bq_full[gs])
            );
        end
    endgenerate

    // AW depends only on aw_* inputs and registered FIFO state
    always_comb begin
        logic [M-1:0] req;
        logic [MW:0]  pick;
        aw_grant_f = '0;
        wq_push    = '0;
        for (int s = 0; s < S; s++) begin
            wq_din[s]   = '0;
            rr_ptr_d[s] = rr_ptr_q[s];
            req = '0;
            for (int m = 0; m < M; m++) begin
                req[m] = aw_valid_f[m] && (aw_sel[m] == SW'(s)) && !mq_full[m];
            end
            pick = rr_pick(req, rr_ptr_q[s]);
            if (pick[MW] && !wq_full[s] && !clr) begin
                aw_grant_f[pick[MW-1:0]] = 1'b1;
                wq_push[s]  = 1'b1;
                wq_din[s]   = pick[MW-1:0];
                rr_ptr_d[s] = MW'((int'(pick[MW-1:0]) + 1) % M);
            end
        end
    end

    // a master's W path opens only when it is at the head of its target slave's queue
    always_comb begin
        logic [SW-1:0] hs;
        w_grant_f = '0;
        w_sel_f   = '0;
        mq_pop    = '0;
        wq_pop    = '0;
        bq_push   = '0;
        for (int s = 0; s < S; s++) bq_din[s] = '0;
        for (int m = 0; m < M; m++) begin
            hs = mq_head[m];
            if (!clr && !mq_empty[m] && !wq_empty[hs] && (wq_head[hs] == MW'(m)) && !bq_full[hs]) begin
                w_grant_f[m]          = 1'b1;
                w_sel_f[m*SW +: SW]   = hs;
                if (w_valid_f[m] && w_last_f[m]) begin
                    mq_pop[m]   = 1'b1;
                    wq_pop[hs]  = 1'b1;
                    bq_push[hs] = 1'b1;
                    bq_din[hs]  = MW'(m);
                end
            end
        end
    end

    always_comb begin
        b_grant_f = '0;
        b_sel_f   = '0;
        bq_pop    = '0;
        for (int s = 0; s < S; s++) begin
            if (!clr && !bq_empty[s]) begin
                b_grant_f[s]        = 1'b1;
                b_sel_f[s*MW +: MW] = bq_head[s];
                bq_pop[s]           = b_valid_f[s] && b_ready_f[bq_head[s]];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < S; s++) begin
            if (clr) rr_ptr_q[s] <= '0;
            else     rr_ptr_q[s] <= rr_ptr_d[s];
        end
    end

endmodule

// File: tb/tb_write_arbiter_rr.sv
// tb/tb_write_arbiter_rr.sv - directed self-checking bench for write_arbiter_rr
module tb_write_arbiter_rr;
    logic         clk;
    logic         clr;
    logic [3:0]   aw_valid_f;
    logic [127:0] aw_addr_f;
    logic [3:0]   aw_grant_f;
    logic [7:0]   aw_sel_f;
    logic [3:0]   w_valid_f;
    logic [3:0]   w_last_f;
    logic [3:0]   w_grant_f;
    logic [7:0]   w_sel_f;
    logic [3:0]   b_valid_f;
    logic [3:0]   b_ready_f;
    logic [3:0]   b_grant_f;
    logic [7:0]   b_sel_f;

    int tests_run;
    int tests_failed;

    write_arbiter_rr #(
        .M(4), .S(4), .DEPTH(4), .ADDR_WIDTH(32), .SLICE_SIZE(32'h80)
    ) dut (
        .clk(clk), .clr(clr),
        .aw_valid_f(aw_valid_f), .aw_addr_f(aw_addr_f),
        .aw_grant_f(aw_grant_f), .aw_sel_f(aw_sel_f),
        .w_valid_f(w_valid_f), .w_last_f(w_last_f),
        .w_grant_f(w_grant_f), .w_sel_f(w_sel_f),
        .b_valid_f(b_valid_f), .b_ready_f(b_ready_f),
        .b_grant_f(b_grant_f), .b_sel_f(b_sel_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int m, input logic [31:0] a);
        aw_addr_f[m*32 +: 32] = a;
    endtask

    task automatic idle_inputs();
        aw_valid_f = '0;
        aw_addr_f  = '0;
        w_valid_f  = '0;
        w_last_f   = '0;
        b_valid_f  = '0;
        b_ready_f  = '0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        idle_inputs();
        tick();
        tick();
        clr = 1'b0;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // reset with every input active
        clr        = 1'b1;
        aw_valid_f = 4'hf;
        set_addr(0, 32'h000); set_addr(1, 32'h080); set_addr(2, 32'h100); set_addr(3, 32'h180);
        w_valid_f  = 4'hf; w_last_f = 4'hf; b_valid_f = 4'hf; b_ready_f = 4'hf;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_aw_grant", 32'(aw_grant_f), 32'h0);
            check("rst_w_grant",  32'(w_grant_f),  32'h0);
            check("rst_b_grant",  32'(b_grant_f),  32'h0);
            check("rst_w_sel",    32'(w_sel_f),    32'h0);
            check("rst_b_sel",    32'(b_sel_f),    32'h0);
            check("rst_aw_sel",   32'(aw_sel_f),   32'he4);
        end
        clr = 1'b0;
        #1;
        check("first_aw_grant", 32'(aw_grant_f), 32'hf);
        do_reset();

        // contention on slave 0
        aw_valid_f = 4'b0111;
        #1;
        check("rr_c0", 32'(aw_grant_f), 32'h1);
        tick();
        check("rr_c1", 32'(aw_grant_f), 32'h2);
        tick();
        check("rr_c2", 32'(aw_grant_f), 32'h4);
        tick();
        check("rr_c3", 32'(aw_grant_f), 32'h1);
        do_reset();

        // parallel accepts to two slaves
        set_addr(0, 32'h000); set_addr(1, 32'h080);
        aw_valid_f = 4'b0011;
        #1;
        check("par_aw_grant", 32'(aw_grant_f), 32'h3);
        check("par_w_grant_same_cycle", 32'(w_grant_f), 32'h0);
        tick();
        aw_valid_f = '0;
        #1;
        check("par_w_grant", 32'(w_grant_f), 32'h3);
        check("par_w_sel",   32'(w_sel_f),   32'h04);
        do_reset();

        // ordering on slave 2
        set_addr(0, 32'h100); set_addr(1, 32'h100);
        aw_valid_f = 4'b0001;
        #1;
        check("ord_aw0", 32'(aw_grant_f), 32'h1);
        tick();
        aw_valid_f = 4'b0010;
        #1;
        check("ord_aw1", 32'(aw_grant_f), 32'h2);
        tick();
        aw_valid_f = '0;
        w_valid_f = 4'b0010; w_last_f = 4'b0010;
        #1;
        check("ord_w_m1_blocked", 32'(w_grant_f), 32'h1);
        tick();
        w_valid_f = 4'b0011; w_last_f = 4'b0011;
        #1;
        check("ord_w_m0_grant", 32'(w_grant_f), 32'h1);
        check("ord_w_m0_sel",   32'(w_sel_f),   32'h02);
        tick();
        check("ord_w_m1_grant", 32'(w_grant_f), 32'h2);
        check("ord_w_m1_sel",   32'(w_sel_f),   32'h08);
        check("ord_b_grant0",   32'(b_grant_f), 32'h4);
        check("ord_b_sel0",     32'(b_sel_f),   32'h00);
        tick();
        w_valid_f = '0; w_last_f = '0;
        b_valid_f = 4'b0100; b_ready_f = 4'hf;
        #1;
        check("ord_w_closed",  32'(w_grant_f), 32'h0);
        check("ord_b_grant1",  32'(b_grant_f), 32'h4);
        tick();
        check("ord_b_sel1",    32'(b_sel_f),   32'h10);
        tick();
        check("ord_b_done",    32'(b_grant_f), 32'h0);
        do_reset();

        // back-pressure: DEPTH outstanding AWs from M0 to slave 3
        set_addr(0, 32'h180);
        aw_valid_f = 4'b0001;
        #1;
        for (int c = 0; c < 4; c++) begin
            check("bp_accept", 32'(aw_grant_f), 32'h1);
            tick();
        end
        check("bp_full0", 32'(aw_grant_f), 32'h0);
        tick();
        check("bp_full1", 32'(aw_grant_f), 32'h0);
        w_valid_f = 4'b0001; w_last_f = 4'b0001;
        #1;
        check("bp_w_grant",       32'(w_grant_f),  32'h1);
        check("bp_full_pop_same", 32'(aw_grant_f), 32'h0);
        tick();
        w_valid_f = '0; w_last_f = '0;
        #1;
        check("bp_reopen", 32'(aw_grant_f), 32'h1);
        do_reset();

        // B return held by b_ready
        set_addr(2, 32'h080);
        aw_valid_f = 4'b0100;
        #1;
        check("b_aw_grant", 32'(aw_grant_f), 32'h4);
        tick();
        aw_valid_f = '0;
        w_valid_f = 4'b0100; w_last_f = 4'b0100;
        #1;
        check("b_w_grant", 32'(w_grant_f), 32'h4);
        check("b_w_sel",   32'(w_sel_f),   32'h10);
        tick();
        w_valid_f = '0; w_last_f = '0;
        b_valid_f = 4'b0010; b_ready_f = 4'b0000;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("b_hold_grant", 32'(b_grant_f), 32'h2);
            check("b_hold_sel",   32'(b_sel_f),   32'h08);
            tick();
        end
        b_ready_f = 4'b0100;
        #1;
        check("b_ready_grant", 32'(b_grant_f), 32'h2);
        tick();
        b_valid_f = '0; b_ready_f = '0;
        #1;
        check("b_popped_grant", 32'(b_grant_f), 32'h0);
        check("b_popped_sel",   32'(b_sel_f),   32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
